// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative restoring divider, companion to the combinational ALU.
// Returns {remainder, quotient} on out_data through a start/busy/done handshake.
// One restoring step per clock in CALC, followed by a finalize cycle that
// latches the result on entry to DONE.
//
// Build option: define ALU_DIV_SIGNED_EN for two's-complement operands.
// The core still divides magnitudes. One extra cycle then applies the sign
// correction: the quotient truncates toward zero and the remainder takes the
// dividend's sign. Leave it undefined for the plain unsigned divider.

module alu_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data1,
    input  logic [WIDTH-1:0]   in_data2,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Cycles spent in CALC after the restoring steps (sign correction).
`ifdef ALU_DIV_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    localparam int              CNT_W     = $clog2(WIDTH + EXTRA + 2);
    localparam logic [CNT_W-1:0] CNT_EXTRA = CNT_W'(EXTRA);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH + EXTRA);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef ALU_DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Two's-complement negate; MIN maps onto itself, which is what both the
    // magnitude of MIN and the MIN / -1 quotient need.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend bits still to shift in
    logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor (magnitude)
    logic [WIDTH-1:0]     quo_q, quo_d;     // quotient being built
    logic                 dz_q, dz_d;       // current operation has divisor 0
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 div_zero_q, div_zero_d;
`ifdef ALU_DIV_SIGNED_EN
    logic                 q_neg_q, q_neg_d; // negate quotient at the end
    logic                 r_neg_q, r_neg_d; // negate remainder at the end
`endif

    logic [WIDTH:0]       rem_sh;           // {rem, next dividend bit}
    logic [WIDTH-1:0]     diff;
    logic                 no_borrow;
    logic                 accept;
    logic                 zero_div;

    // Trial subtraction for one restoring step. When no borrow occurs the true
    // difference is below the divisor, so its low WIDTH bits are exact.
    always_comb begin
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        no_borrow = (rem_sh >= {1'b0, dvs_q});
        diff      = rem_sh[WIDTH-1:0] - dvs_q;
        accept    = start && (state_q != CALC);
        zero_div  = (in_data2 == '0);
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        dz_d       = dz_q;
        out_d      = out_q;
        div_zero_d = div_zero_q;
`ifdef ALU_DIV_SIGNED_EN
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
`endif

        case (state_q)
            CALC: begin
                if (cnt_q == '0) begin
                    // Finalize: latch the result as DONE is entered.
                    state_d    = DONE;
                    out_d      = {rem_q, quo_q};
                    div_zero_d = dz_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (!dz_q && (cnt_q > CNT_EXTRA)) begin
                        rem_d = no_borrow ? diff : rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], no_borrow};
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
`ifdef ALU_DIV_SIGNED_EN
                    else if (!dz_q) begin
                        // Sign-correction cycle after the last restoring step.
                        if (q_neg_q) quo_d = negate(quo_q);
                        if (r_neg_q) rem_d = negate(rem_q);
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // A start in IDLE or DONE is accepted; in CALC it is ignored.
        if (accept) begin
            state_d = CALC;
            dz_d    = zero_div;
            cnt_d   = zero_div ? CNT_EXTRA : CNT_LOAD;
            // A zero divisor preloads the fixed answer: quotient all ones,
            // remainder equal to the dividend as given.
            rem_d   = zero_div ? in_data1 : '0;
            quo_d   = zero_div ? '1 : '0;
`ifdef ALU_DIV_SIGNED_EN
            dvd_d   = magnitude(in_data1);
            dvs_d   = magnitude(in_data2);
            q_neg_d = in_data1[WIDTH-1] ^ in_data2[WIDTH-1];
            r_neg_d = in_data1[WIDTH-1];
`else
            dvd_d   = in_data1;
            dvs_d   = in_data2;
`endif
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            // NOTE: all datapath registers are reset as well, so an aborted operation leaves no stale state behind.
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            dz_q       <= 1'b0;
            out_q      <= '0;
            div_zero_q <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            quo_q      <= quo_d;
            dz_q       <= dz_d;
            out_q      <= out_d;
            div_zero_q <= div_zero_d;
`ifdef ALU_DIV_SIGNED_EN
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
`endif
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        busy     = (state_q == CALC);
        done     = (state_q == DONE);
        div_zero = div_zero_q;
        out_data = out_q;
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq (WIDTH=4): a directed vector table plus
// hand-written sequences for back-to-back, ignored start and mid-op reset.
// Expected values follow the build option ALU_DIV_SIGNED_EN.

module tb_alu_div_seq;

    localparam int W = 4;

`ifdef ALU_DIV_SIGNED_EN
    localparam int         LAT     = W + 2;
    localparam int         LAT_Z   = 2;
    localparam logic [7:0] EXP_13_3 = 8'h0F;  // -3 / 3
    localparam logic [7:0] EXP_9_4  = 8'hDF;  // -7 / 4
`else
    localparam int         LAT     = W + 1;
    localparam int         LAT_Z   = 1;
    localparam logic [7:0] EXP_13_3 = 8'h14;
    localparam logic [7:0] EXP_9_4  = 8'h12;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in_data1 = '0;
    logic [W-1:0] in_data2 = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [2*W-1:0] out_data;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_out;
        logic           exp_dz;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .out_data (out_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge; start is sampled at the next edge (edge N).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        in_data1 = a;
        in_data2 = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Counts edges after edge N until done is seen; bounded.
    task automatic wait_done(input string name, input int exp_lat,
                             input logic [2*W-1:0] exp_out, input logic exp_dz);
        int   n;
        logic busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        check({name, "_latency"}, n, exp_lat);
        check({name, "_out"}, {24'd0, out_data}, {24'd0, exp_out});
        check({name, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
        check({name, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Watches a number of cycles and requires that done never rises.
    task automatic expect_no_done(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check({name, "_no_done"}, pulses, 0);
    endtask

    initial begin
`ifdef ALU_DIV_SIGNED_EN
        tbl[0] = '{4'h9, 4'h2, 8'hFD, 1'b0};  // -7 / 2
        tbl[1] = '{4'h8, 4'hF, 8'h08, 1'b0};  // MIN / -1
        tbl[2] = '{4'h7, 4'h2, 8'h13, 1'b0};
        tbl[3] = '{4'h7, 4'h0, 8'h7F, 1'b1};
        tbl[4] = '{4'h9, 4'hE, 8'hF3, 1'b0};  // -7 / -2
        tbl[5] = '{4'h6, 4'hD, 8'h0E, 1'b0};  // 6 / -3
        tbl[6] = '{4'h0, 4'h0, 8'h0F, 1'b1};
        tbl[7] = '{4'h1, 4'hF, 8'h0F, 1'b0};  // 1 / -1
        tbl[8] = '{4'h8, 4'h1, 8'h08, 1'b0};  // MIN / 1
        tbl[9] = '{4'hF, 4'h2, 8'hF0, 1'b0};  // -1 / 2
`else
        tbl[0] = '{4'd13, 4'd3,  8'h14, 1'b0};
        tbl[1] = '{4'd15, 4'd1,  8'h0F, 1'b0};
        tbl[2] = '{4'd3,  4'd9,  8'h30, 1'b0};
        tbl[3] = '{4'd7,  4'd0,  8'h7F, 1'b1};
        tbl[4] = '{4'd9,  4'd4,  8'h12, 1'b0};
        tbl[5] = '{4'd0,  4'd5,  8'h00, 1'b0};
        tbl[6] = '{4'd15, 4'd15, 8'h01, 1'b0};
        tbl[7] = '{4'd1,  4'd15, 8'h10, 1'b0};
        tbl[8] = '{4'd0,  4'd0,  8'h0F, 1'b1};
        tbl[9] = '{4'd15, 4'd2,  8'h17, 1'b0};
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dz", {31'd0, div_zero}, 32'd0);
        check("reset_out", {24'd0, out_data}, 32'd0);

        // 13/3 basic latency and result.
        launch(4'd13, 4'd3);
        check("op13_3_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("op13_3", LAT, EXP_13_3, 1'b0);

        // Back-to-back: second start asserted in the done cycle.
        @(posedge clk);
        #1;
        launch(4'd3, 4'd9);
        wait_done("b2b_first", LAT, 8'h30, 1'b0);
        launch(4'd15, 4'd1);
        check("b2b_done_single_cycle", {31'd0, done}, 32'd0);
        check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", LAT, 8'h0F, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        @(posedge clk);
        #1;
        launch(4'd7, 4'd0);
        wait_done("dz_7_0", LAT_Z, 8'h7F, 1'b1);
        @(posedge clk);
        #1;
        check("dz_held_after_done", {31'd0, div_zero}, 32'd1);
        launch(4'd6, 4'd2);
        check("dz_held_until_done", {31'd0, div_zero}, 32'd1);
        wait_done("op6_2", LAT, 8'h03, 1'b0);

        // start pulsed with 1/1 while busy is ignored.
        @(posedge clk);
        #1;
        launch(4'd13, 4'd3);
        @(posedge clk);
        #1;
        in_data1 = 4'd1;
        in_data2 = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        wait_done("ignored_start", LAT - 2, EXP_13_3, 1'b0);
        expect_no_done("ignored_start", 8);

        // Reset during the second CALC cycle aborts with no done pulse.
        launch(4'd13, 4'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_out", {24'd0, out_data}, 32'd0);
        check("midreset_dz", {31'd0, div_zero}, 32'd0);
        expect_no_done("midreset", 8);
        launch(4'd9, 4'd4);
        wait_done("after_reset_9_4", LAT, EXP_9_4, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            launch(tbl[i].a, tbl[i].b);
            wait_done($sformatf("vec%0d", i), tbl[i].exp_dz ? LAT_Z : LAT,
                      tbl[i].exp_out, tbl[i].exp_dz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
